// File: rtl/seq_serializer_pkg.sv
// Shared constants for the serializer and the detector-side bench.
// State encoding plus default word and counter widths.
package seq_serializer_pkg;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'b00,
    SER_SHIFT = 2'b01
  } ser_state_t;

  localparam int SER_WIDTH = 8;
  localparam int SER_CNT_W = 16;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the sequence detector.
// Back-to-back words shift out with no idle bit between them.
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH      = SER_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int CNT_W      = SER_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             en,
  output logic             seq,
  output logic             seq_valid,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0]    bitcnt;
  logic             last;

  assign last      = (state == SER_SHIFT) && en
                     && (bitcnt == LAST);
  assign din_ready = (state == SER_IDLE) || last;
  assign seq_valid = (state == SER_SHIFT);

  always_comb begin
    seq = IDLE_LEVEL;
    if (seq_valid)
      seq = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  end

  // Shift toward whichever end feeds seq, zero fill.
  always_comb begin
    if (MSB_FIRST)
      shifted = {shreg[WIDTH-2:0], 1'b0};
    else
      shifted = {1'b0, shreg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SER_IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        SER_IDLE: begin
          if (din_valid) begin
            shreg  <= din;
            bitcnt <= '0;
            state  <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (en) begin
            if (bitcnt == LAST) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + CNT_W'(1);
              // Reload in place so the next word follows gap-free.
              if (din_valid) begin
                shreg  <= din;
                bitcnt <= '0;
              end else begin
                state <= SER_IDLE;
              end
            end else begin
              shreg  <= shifted;
              bitcnt <= bitcnt + BW'(1);
            end
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-to-serial feeder directly upstream of the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per enabled clock on a single-bit serial output, which drives the detector's seq input.
- Supports back-to-back words with no idle bit between them, so detector patterns spanning word boundaries are preserved.
- Counts completed frames.

Parameters:
- WIDTH, 8, bits per parallel word (2..32).
- MSB_FIRST, 1, 1 = shift MSB out first, 0 = LSB first.
- IDLE_LEVEL, 0, value driven on seq when no word is being shifted.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- din  input  WIDTH  parallel word.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block accepts din this cycle.
- en  input  1  bit-rate enable; serial state advances only when 1.
- seq  output  1  serial bit to detector.
- seq_valid  output  1  seq carries a data bit.
- frame_done  output  1  one-cycle pulse after last bit of a word is consumed.
- frame_cnt  output  CNT_W  completed frames, wraps.

Behaviour:
- States: IDLE, SHIFT (2-bit encoding, IDLE = 2'b00, SHIFT = 2'b01, others -> IDLE).
- Registers: shreg[WIDTH-1:0], bitcnt[$clog2(WIDTH)-1:0], state, frame_done, frame_cnt.
- Reset (rst = 0, async):
  - state = IDLE, shreg = 0, bitcnt = 0, frame_done = 0, frame_cnt = 0.
  - seq = IDLE_LEVEL, seq_valid = 0.
- din_ready is combinational: (state == IDLE) || (state == SHIFT && en && bitcnt == WIDTH-1).
  - It is 1 while in reset because state = IDLE; no transfer occurs in reset.
- Transfer occurs at a rising edge when din_valid && din_ready.
- IDLE:
  - On transfer: shreg <= din, bitcnt <= 0, state <= SHIFT. en is ignored for the load.
  - Otherwise hold.
- seq output:
  - seq = shreg[WIDTH-1] (MSB_FIRST = 1) or shreg[0] (MSB_FIRST = 0) when state == SHIFT, else IDLE_LEVEL.
  - seq_valid = (state == SHIFT).
  - Latency: the first bit appears on seq in the cycle after the transfer edge.
- SHIFT, en = 0: all registers hold; seq is stable.
- SHIFT, en = 1, bitcnt < WIDTH-1:
  - shreg shifts toward the output end (left if MSB_FIRST, right otherwise), zero fill.
  - bitcnt++.
- SHIFT, en = 1, bitcnt == WIDTH-1 (last bit consumed):
  - frame_done <= 1 for exactly one cycle; frame_cnt <= frame_cnt + 1 (modulo 2^CNT_W).
  - If din_valid: load the new word, bitcnt <= 0, stay in SHIFT. No gap cycle; the next word's first bit follows immediately.
  - Else: state <= IDLE.
- frame_done is 0 in every cycle other than those above.
- din must be held stable by the source while din_valid = 1 and din_ready = 0.
  - din_valid dropping without a transfer is legal and has no effect.
- Each word produces exactly WIDTH enabled cycles of seq_valid.
- Reset asserted mid-frame: the word is discarded immediately and frame_cnt is not incremented. After release, a new transfer is required.

Decomposition:
- Shared package: state encoding constants (SER_IDLE, SER_SHIFT) and default WIDTH/CNT_W constants, reusable by the detector-side bench.
- No sub-module; single module (est. 150 RTL lines).

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, en=1, din=8'hD6:
  - seq = 1,1,0,1,0,1,1,0 on cycles 1..8 after transfer, seq_valid high for 8 cycles.
  - frame_done pulse on cycle 9; frame_cnt = 1; then seq = 0, seq_valid = 0.
- Back-to-back, din=8'hF0 then 8'h0F with din_valid held:
  - din_ready high only in IDLE and on the last-bit cycle.
  - 16 contiguous seq_valid cycles, seq = 11110000 00001111, two frame_done pulses 8 cycles apart, frame_cnt = 2.
- en stalls, en pattern 1,0,0,1,... on din=8'hA5:
  - seq holds each bit across en=0 cycles; output order still 10100101.
  - frame_done only after the 8th enabled cycle.
- MSB_FIRST=0, din=8'h01: seq = 1,0,0,0,0,0,0,0.
- Reset mid-frame, rst=0 after 3 bits of 8'hFF:
  - seq = IDLE_LEVEL and seq_valid = 0 immediately (async), frame_cnt = 0.
  - The next word after release transmits fully.
- CNT_W=4 bench, 17 words: frame_cnt wraps 15 -> 0 -> 1; frame_done count = 17.
